// File: rtl/framebuffer_arbiter_if.sv
// Framebuffer arbiter bus: scanout read port, pixel write port and the single-port RAM command/return path.
// slave = arbiter side, master = requester/RAM side.
interface framebuffer_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    output rd_ready, rd_valid, rd_data, wr_ack, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    input  rd_ready, rd_valid, rd_data, wr_ack, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Shares one single-port framebuffer RAM between scanout reads and pixel writes; read data returns 3 clk after accept.
// Backpressure: rd_ready drops while the 2-entry read queue is full; writes hold wr_req until the wr_ack pulse.
module fb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

module framebuffer_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic                  scan_active,
  framebuffer_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic [ADDR_W-1:0] q_head;
  logic              rd_pend;
  logic              wr_pend;
  logic              grant_wr;
  logic              grant_rd;
  logic [SW-1:0]     starve_cnt;
  logic              rd_issued;

  assign bus.rd_ready = !q_full;
  assign q_push       = bus.rd_req && !q_full;

  fb_fifo #(.WIDTH(ADDR_W), .DEPTH(2)) u_rd_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (q_push),
    .push_dat (bus.rd_addr),
    .full     (q_full),
    .pop      (grant_rd),
    .pop_dat  (q_head),
    .empty    (q_empty)
  );

  // The ack cycle masks wr_req so a held request is not written twice.
  assign rd_pend  = !q_empty;
  assign wr_pend  = bus.wr_req && !bus.wr_ack;
  assign grant_wr = wr_pend && (!rd_pend || !scan_active || starve_cnt == STARVE_MAX);
  assign grant_rd = rd_pend && !grant_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_wr || !wr_pend) begin
      starve_cnt <= '0;
    end else if (grant_rd && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.wr_ack    <= 1'b0;
    end else begin
      bus.ram_en <= grant_wr || grant_rd;
      bus.ram_we <= grant_wr;
      bus.wr_ack <= grant_wr;
      if (grant_wr) begin
        bus.ram_addr  <= bus.wr_addr;
        bus.ram_wdata <= bus.wr_data;
      end else if (grant_rd) begin
        bus.ram_addr <= q_head;
      end
    end
  end

  // rd_issued tracks the RAM's one-cycle read latency; clearing it on reset drops any in-flight return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_issued    <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      rd_issued    <= bus.ram_en && !bus.ram_we;
      bus.rd_valid <= rd_issued;
      if (rd_issued) bus.rd_data <= bus.ram_rdata;
    end
  end
endmodule
